input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 22 ++
 rtl/input_conditioner_if.sv | 24 ++
 rtl/input_conditioner_debounce_cell.sv | 50 +++++
 rtl/input_conditioner.sv | 79 +++++++
 tb/tb_input_conditioner.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner: request FSM encoding,
// default parameter values and the debounce counter width helper.
package input_conditioner_pkg;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int STATE_W             = 5;
   // bit 0 is the start switch, bits STATE_W:1 are the state-select switches
   localparam int NUM_BITS            = STATE_W + 1;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PENDING      = 2'd1,
      WAIT_RELEASE = 2'd2
   } req_state_e;

   // Counter must be able to hold the value DEBOUNCE_CYCLES itself.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Switch/controller side signals of the input conditioner.
// master = stimulus/controller side, slave = the conditioner.
interface input_conditioner_if;
   import input_conditioner_pkg::*;

   logic               start_raw;
   logic [STATE_W-1:0] state_raw;
   logic               start_ack;
   logic               start_req;
   logic [STATE_W-1:0] state_out;
   logic               start_db;
   logic               overrun;

   modport master (
      output start_raw, state_raw, start_ack,
      input  start_req, state_out, start_db, overrun
   );

   modport slave (
      input  start_raw, state_raw, start_ack,
      output start_req, state_out, start_db, overrun
   );

endinterface

// File: rtl/input_conditioner_debounce_cell.sv
// One switch bit: SYNC_STAGES-deep synchronizer, mismatch counter and
// debounced level flop.
module debounce_cell
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CMAX = CW'(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   db;
   logic                   s;

   assign s    = sync[SYNC_STAGES-1];
   assign dout = db;

   // Synchronizer shift chain; the raw switch is only ever seen through it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], din};
   end

   // Count samples that disagree with the debounced level. Once the count has
   // reached DEBOUNCE_CYCLES and the disagreement persists, commit the new
   // level and restart. Any agreeing sample clears the count, so the counter
   // tops out at CMAX and cannot wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         db  <= 1'b0;
      end else if (s == db) begin
         cnt <= '0;
      end else if (cnt >= CMAX) begin
         db  <= s;
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Debounces the start and state-select switches and turns a start press
// into a held request with the state selection captured alongside it.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
   input  logic                 clk,
   input  logic                 reset,
   input_conditioner_if.slave   bus
);

   logic [NUM_BITS-1:0] raw;
   logic [NUM_BITS-1:0] db;
   logic                start_q;
   req_state_e          state;
   logic                req_r;
   logic [STATE_W-1:0]  state_out_r;
   logic                overrun_r;

   assign raw = {bus.state_raw, bus.start_raw};

   for (genvar g = 0; g < NUM_BITS; g++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_cell (
         .clk   (clk),
         .reset (reset),
         .din   (raw[g]),
         .dout  (db[g])
      );
   end

   assign bus.start_db  = db[0];
   assign bus.start_req = req_r;
   assign bus.state_out = state_out_r;
   assign bus.overrun   = overrun_r;

   // Request FSM. IDLE is only entered with debounced start low (or from
   // reset), so a high level seen in IDLE is always a fresh press. In PENDING
   // a rise needs a prior fall, which is exactly the overrun condition.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         req_r       <= 1'b0;
         state_out_r <= '0;
         overrun_r   <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         start_q <= db[0];
         case (state)
            IDLE: begin
               if (db[0]) begin
                  state       <= PENDING;
                  req_r       <= 1'b1;
                  state_out_r <= db[NUM_BITS-1:1];
               end
            end
            PENDING: begin
               if (db[0] && !start_q) overrun_r <= 1'b1;
               if (bus.start_ack) begin
                  state <= WAIT_RELEASE;
                  req_r <= 1'b0;
               end
            end
            WAIT_RELEASE: begin
               if (!db[0]) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               req_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Captured state values are queued at press time and popped on start_req rise.
module tb_input_conditioner;
   import input_conditioner_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   input_conditioner_if bus();

   input_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [4:0] exp_q[$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input int budget, output bit seen);
      int i;
      seen = 1'b0;
      i = 0;
      while (!seen && i < budget) begin
         @(negedge clk);
         if (bus.start_req === 1'b1) seen = 1'b1;
         i++;
      end
   endtask

   task automatic do_reset();
      bus.start_raw = 1'b0;
      bus.state_raw = 5'h00;
      bus.start_ack = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(1);
   endtask

   task automatic test_reset();
      bus.start_raw = 1'b1;
      bus.state_raw = 5'h1f;
      bus.start_ack = 1'b0;
      reset = 1'b0;
      cyc(3);
      checks++; if (bus.start_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.start_req); end
      checks++; if (bus.state_out !== 5'h00) begin errors++; $display("FAIL reset_state_out got %h exp 00", bus.state_out); end
      checks++; if (bus.start_db !== 1'b0) begin errors++; $display("FAIL reset_db got %b exp 0", bus.start_db); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
   endtask

   task automatic test_latency();
      logic exp_db, exp_req;
      logic [4:0] e;
      do_reset();
      exp_q.push_back(5'h00);
      bus.start_raw = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_db  = (k >= 6);
         exp_req = (k >= 7);
         checks++; if (bus.start_db !== exp_db) begin errors++; $display("FAIL latency_db edge %0d got %b exp %b", k, bus.start_db, exp_db); end
         checks++; if (bus.start_req !== exp_req) begin errors++; $display("FAIL latency_req edge %0d got %b exp %b", k, bus.start_req, exp_req); end
      end
      e = exp_q.pop_front();
      checks++; if (bus.state_out !== e) begin errors++; $display("FAIL latency_state_out got %h exp %h", bus.state_out, e); end
   endtask

   task automatic test_glitch();
      do_reset();
      bus.start_raw = 1'b1;
      cyc(3);
      bus.start_raw = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         checks++; if (bus.start_db !== 1'b0) begin errors++; $display("FAIL glitch_db cycle %0d got %b exp 0", k, bus.start_db); end
         checks++; if (bus.start_req !== 1'b0) begin errors++; $display("FAIL glitch_req cycle %0d got %b exp 0", k, bus.start_req); end
         checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL glitch_overrun cycle %0d got %b exp 0", k, bus.overrun); end
      end
   endtask

   task automatic test_state_capture();
      bit seen;
      logic [4:0] e;
      do_reset();
      bus.state_raw = 5'h13;
      cyc(10);
      exp_q.push_back(5'h13);
      bus.start_raw = 1'b1;
      wait_req(20, seen);
      checks++; if (!seen) begin errors++; $display("FAIL capture_req_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (bus.state_out !== e) begin errors++; $display("FAIL capture_state_out got %h exp %h", bus.state_out, e); end
      bus.state_raw = 5'h05;
      cyc(10);
      checks++; if (bus.state_out !== 5'h13) begin errors++; $display("FAIL capture_hold got %h exp 13", bus.state_out); end
      checks++; if (bus.start_req !== 1'b1) begin errors++; $display("FAIL capture_req_held got %b exp 1", bus.start_req); end
      bus.start_ack = 1'b1;
      @(negedge clk);
      bus.start_ack = 1'b0;
      checks++; if (bus.start_req !== 1'b0) begin errors++; $display("FAIL capture_ack_drop got %b exp 0", bus.start_req); end
      bus.start_raw = 1'b0;
      cyc(12);
      checks++; if (bus.state_out !== 5'h13) begin errors++; $display("FAIL capture_after_release got %h exp 13", bus.state_out); end
      exp_q.push_back(5'h05);
      bus.start_raw = 1'b1;
      wait_req(20, seen);
      checks++; if (!seen) begin errors++; $display("FAIL capture_second_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (bus.state_out !== e) begin errors++; $display("FAIL capture_second_state_out got %h exp %h", bus.state_out, e); end
   endtask

   task automatic test_overrun();
      bit seen, stay_high;
      logic [4:0] e;
      do_reset();
      exp_q.push_back(5'h00);
      bus.start_raw = 1'b1;
      wait_req(20, seen);
      checks++; if (!seen) begin errors++; $display("FAIL overrun_first_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (bus.state_out !== e) begin errors++; $display("FAIL overrun_first_state_out got %h exp %h", bus.state_out, e); end
      stay_high = 1'b1;
      bus.start_raw = 1'b0;
      for (int k = 0; k < 10; k++) begin @(negedge clk); if (bus.start_req !== 1'b1) stay_high = 1'b0; end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_after_fall got %b exp 0", bus.overrun); end
      bus.start_raw = 1'b1;
      for (int k = 0; k < 10; k++) begin @(negedge clk); if (bus.start_req !== 1'b1) stay_high = 1'b0; end
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", bus.overrun); end
      checks++; if (stay_high !== 1'b1) begin errors++; $display("FAIL overrun_req_held got %b exp 1", stay_high); end
      bus.start_ack = 1'b1;
      @(negedge clk);
      bus.start_ack = 1'b0;
      checks++; if (bus.start_req !== 1'b0) begin errors++; $display("FAIL overrun_ack_drop got %b exp 0", bus.start_req); end
      bus.start_raw = 1'b0;
      cyc(10);
      exp_q.push_back(5'h00);
      bus.start_raw = 1'b1;
      wait_req(20, seen);
      checks++; if (!seen) begin errors++; $display("FAIL overrun_idle_return got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (bus.state_out !== e) begin errors++; $display("FAIL overrun_second_state_out got %h exp %h", bus.state_out, e); end
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", bus.overrun); end
      do_reset();
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_reset_clear got %b exp 0", bus.overrun); end
   endtask

   task automatic test_reset_mid_request();
      bit seen;
      logic [4:0] e;
      logic exp_db, exp_req;
      do_reset();
      bus.state_raw = 5'h1a;
      cyc(10);
      exp_q.push_back(5'h1a);
      bus.start_raw = 1'b1;
      wait_req(20, seen);
      checks++; if (!seen) begin errors++; $display("FAIL midreset_first_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (bus.state_out !== e) begin errors++; $display("FAIL midreset_first_state_out got %h exp %h", bus.state_out, e); end
      #2 reset = 1'b0;
      #1;
      checks++; if (bus.start_req !== 1'b0) begin errors++; $display("FAIL midreset_async_req got %b exp 0", bus.start_req); end
      checks++; if (bus.state_out !== 5'h00) begin errors++; $display("FAIL midreset_async_state_out got %h exp 00", bus.state_out); end
      checks++; if (bus.start_db !== 1'b0) begin errors++; $display("FAIL midreset_async_db got %b exp 0", bus.start_db); end
      cyc(2);
      reset = 1'b1;
      exp_q.push_back(5'h1a);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_db  = (k >= 6);
         exp_req = (k >= 7);
         checks++; if (bus.start_db !== exp_db) begin errors++; $display("FAIL midreset_db edge %0d got %b exp %b", k, bus.start_db, exp_db); end
         checks++; if (bus.start_req !== exp_req) begin errors++; $display("FAIL midreset_req edge %0d got %b exp %b", k, bus.start_req, exp_req); end
      end
      e = exp_q.pop_front();
      checks++; if (bus.state_out !== e) begin errors++; $display("FAIL midreset_state_out got %h exp %h", bus.state_out, e); end
   endtask

   task automatic test_ack_held();
      bit seen;
      logic [4:0] e;
      int hi;
      do_reset();
      bus.start_ack = 1'b1;
      cyc(3);
      exp_q.push_back(5'h00);
      bus.start_raw = 1'b1;
      wait_req(20, seen);
      checks++; if (!seen) begin errors++; $display("FAIL ackheld_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (bus.state_out !== e) begin errors++; $display("FAIL ackheld_state_out got %h exp %h", bus.state_out, e); end
      hi = seen ? 1 : 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.start_req === 1'b1) hi++;
      end
      checks++; if (hi != 1) begin errors++; $display("FAIL ackheld_width got %0d cycles exp 1", hi); end
      bus.start_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_state_capture();
      test_overrun();
      test_reset_mid_request();
      test_ack_held();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
